// File: rtl/i2s_pkg.sv
// Shared types and defaults for the I2S receive path.
// Holds the FSM state and channel enums used by i2s_rx.
package i2s_pkg;

  localparam int I2S_SAMPLE_W_DEFAULT = 24;

  typedef enum logic [1:0] {
    IDLE,
    SKIP,
    SHIFT,
    DRAIN
  } rx_state_t;

  typedef enum logic {
    CH_L = 1'b0,
    CH_R = 1'b1
  } chan_t;

endpackage

// File: rtl/i2s_rx_edge_sync.sv
// Multi-flop synchronizer for an asynchronous pin plus a history
// flop, giving the synchronized level and its rise/fall strobes.
module edge_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;
  logic              hist_q;
  logic              hist_d;

  // Shift the pin into the chain and remember the previous level
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
    hist_d = sync_q[STAGES-1];
  end

  // Synchronizer and history registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = level & ~hist_q;
  assign fall  = ~level & hist_q;

endmodule

// File: rtl/i2s_rx.sv
// I2S receiver: oversamples SCLK/LRCLK/Din in the CLK domain and
// emits stereo pairs on valid/ready. Option macro: I2S_RX_OVERRUN_EN.
module i2s_rx
  import i2s_pkg::*;
#(
  parameter int SAMPLE_W    = I2S_SAMPLE_W_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                SCLK,
  input  logic                LRCLK,
  input  logic                Din,
  output logic [SAMPLE_W-1:0] sample_left,
  output logic [SAMPLE_W-1:0] sample_right,
  output logic                sample_valid,
  input  logic                sample_ready,
  output logic                frame_err,
  output logic                overrun
);

  localparam int CNT_W = $clog2(SAMPLE_W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SAMPLE_W - 1);

  logic sclk_level_unused;
  logic sclk_fall_unused;
  logic sclk_rise;
  logic lr_lvl;
  logic lr_rise;
  logic lr_fall;
  logic lr_edge;
  logic din;

  edge_sync #(.STAGES(SYNC_STAGES)) u_sclk (
    .clk  (CLK),
    .rst  (RESET),
    .d    (SCLK),
    .level(sclk_level_unused),
    .rise (sclk_rise),
    .fall (sclk_fall_unused)
  );

  edge_sync #(.STAGES(SYNC_STAGES)) u_lrclk (
    .clk  (CLK),
    .rst  (RESET),
    .d    (LRCLK),
    .level(lr_lvl),
    .rise (lr_rise),
    .fall (lr_fall)
  );

  assign lr_edge = lr_rise | lr_fall;

  logic [SYNC_STAGES-1:0] din_sync_q;
  logic [SYNC_STAGES-1:0] din_sync_d;

  rx_state_t             state_q, state_d;
  chan_t                 chan_q, chan_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [SAMPLE_W-2:0]   shreg_q, shreg_d;
  logic [SAMPLE_W-1:0]   left_hold_q, left_hold_d;
  logic                  left_ok_q, left_ok_d;
  logic                  frame_err_q, frame_err_d;
  logic [SAMPLE_W-1:0]   left_q, left_d;
  logic [SAMPLE_W-1:0]   right_q, right_d;
  logic                  valid_q, valid_d;
  logic [SAMPLE_W-1:0]   word;
  logic                  pair_done;
  logic                  load;

  // Din only needs the synchronizer; it is sampled on sclk_rise
  always_comb begin
    din_sync_d = {din_sync_q[SYNC_STAGES-2:0], Din};
  end

  assign din  = din_sync_q[SYNC_STAGES-1];
  assign word = {shreg_q, din};

  // Frame alignment and bit capture FSM
  always_comb begin
    state_d     = state_q;
    chan_d      = chan_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    left_hold_d = left_hold_q;
    left_ok_d   = left_ok_q;
    frame_err_d = 1'b0;
    pair_done   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (lr_fall) begin
          state_d   = SKIP;
          chan_d    = CH_L;
          left_ok_d = 1'b0;
        end
      end
      SKIP: begin
        if (lr_edge) begin
          chan_d = chan_t'(lr_lvl);
        end else if (sclk_rise) begin
          state_d   = SHIFT;
          bit_cnt_d = '0;
        end
      end
      SHIFT: begin
        if (lr_edge) begin
          frame_err_d = 1'b1;
          left_ok_d   = 1'b0;
          chan_d      = chan_t'(lr_lvl);
          state_d     = SKIP;
        end else if (sclk_rise) begin
          shreg_d   = word[SAMPLE_W-2:0];
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == LAST) begin
            state_d = DRAIN;
            if (chan_q == CH_L) begin
              left_hold_d = word;
              left_ok_d   = 1'b1;
            end else begin
              pair_done = left_ok_q;
              left_ok_d = 1'b0;
            end
          end
        end
      end
      DRAIN: begin
        if (lr_edge) begin
          chan_d  = chan_t'(lr_lvl);
          state_d = SKIP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef I2S_RX_OVERRUN_EN
  logic overrun_q, overrun_d;
`endif

  // Output pair register and valid/ready handshake
  always_comb begin
    left_d  = left_q;
    right_d = right_q;
    valid_d = valid_q;
    load    = pair_done;
`ifdef I2S_RX_OVERRUN_EN
    overrun_d = overrun_q;
    if (pair_done && valid_q && !sample_ready) begin
      load      = 1'b0;
      overrun_d = 1'b1;
    end
`endif
    if (load) begin
      left_d  = left_hold_q;
      right_d = word;
      valid_d = 1'b1;
    end else if (valid_q && sample_ready && !pair_done) begin
      valid_d = 1'b0;
    end
  end

  // State and datapath registers
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      din_sync_q  <= '0;
      state_q     <= IDLE;
      chan_q      <= CH_L;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      left_hold_q <= '0;
      left_ok_q   <= 1'b0;
      frame_err_q <= 1'b0;
      left_q      <= '0;
      right_q     <= '0;
      valid_q     <= 1'b0;
    end else begin
      din_sync_q  <= din_sync_d;
      state_q     <= state_d;
      chan_q      <= chan_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      left_hold_q <= left_hold_d;
      left_ok_q   <= left_ok_d;
      frame_err_q <= frame_err_d;
      left_q      <= left_d;
      right_q     <= right_d;
      valid_q     <= valid_d;
    end
  end

`ifdef I2S_RX_OVERRUN_EN
  // Sticky overrun flag, cleared only by reset
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) overrun_q <= 1'b0;
    else       overrun_q <= overrun_d;
  end
  assign overrun = overrun_q;
`else
  assign overrun = 1'b0;
`endif

  assign sample_left  = left_q;
  assign sample_right = right_q;
  assign sample_valid = valid_q;
  assign frame_err    = frame_err_q;

endmodule
